seq_generator: RTL and testbench
================================

Name: seq_generator

Overview:
Serial bit-pattern generator. It loads a parallel pattern with a bit length and a repeat count, then shifts the pattern out MSB-first on one serial line, optionally repeating it back-to-back. It is the transmit side that drives the `din` input of the team's serial sequence detectors, both in the lab top level and in their benches.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- REP_W, 4, width of the repeat-count field.
- LEN_W, $clog2(WIDTH)+1, width of the length field; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  pattern request.
- load_ready  out  1  generator can accept a pattern.
- load_data  in  WIDTH  pattern, right-aligned; bit [len-1] is sent first.
- load_len  in  LEN_W  number of pattern bits.
- load_reps  in  REP_W  extra repetitions; total frames = load_reps+1.
- en  in  1  bit-advance strobe (e.g. baud tick); tie high for one bit per clk.
- abort  in  1  terminate the current transfer.
- dout  out  1  serial bit.
- dout_valid  out  1  dout carries a pattern bit.
- done  out  1  one-cycle pulse, asserted with the final bit's consumption.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, load_ready=1, dout=0, dout_valid=0, done=0, all counters 0.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - load_ready=1, dout_valid=0, dout=0.
  - On load_valid&load_ready: capture the pattern left-aligned as shreg = load_data << (WIDTH-len).
  - Save the aligned pattern for repeats; bit_cnt=len-1; rep_cnt=load_reps; go to SHIFT.
- Length rules: load_len==0 or load_len>WIDTH is treated as WIDTH.
- SHIFT:
  - load_ready=0; dout=shreg[WIDTH-1]; dout_valid=1.
  - dout and dout_valid come straight from flops, with no combinational path from inputs.
  - A bit is consumed on any edge where en=1. Then shreg shifts left by 1 and bit_cnt decrements.
  - With en=0, everything holds.
- Last bit consumed (bit_cnt==0, en=1):
  - If rep_cnt!=0: reload shreg from the saved pattern, bit_cnt=len-1, rep_cnt-1, stay in SHIFT. There is no bubble between repetitions.
  - If rep_cnt==0: go to IDLE.
- done: combinational, equal to dout_valid & en & final bit of the final repetition (including the parity bit when the feature is enabled). It pulses once per accepted load.
- Latency: pattern accepted on edge t → first bit visible on dout during cycle t+1. With en=1 throughout, a transfer occupies (len)(reps+1) cycles.
- Back-to-back loads: the earliest next acceptance is the cycle after returning to IDLE, so there is one dead cycle with dout_valid=0 between transfers.
- load_valid is ignored when load_ready=0; load_data, load_len and load_reps are sampled only at acceptance.
- abort=1:
  - In SHIFT/PARITY: go to IDLE on the next edge; dout_valid=0 from that edge; no done pulse.
  - abort has priority over en and over completion.
  - In IDLE it has no effect, and a load in the same cycle is still accepted.
- rst mid-transfer: returns to reset values on the next edge; no done pulse.

Optional Feature:
- Macro SEQ_GENERATOR_PARITY_EN.
- When defined:
  - After the last data bit of each repetition, enter PARITY and emit one bit equal to the XOR of the len data bits (even parity), with dout_valid=1 and the same en rule.
  - Then reload for the next repetition or return to IDLE.
  - done fires on the final parity bit.
  - Frame length becomes len+1.
- When undefined: no PARITY state and no parity bit; behaviour is exactly as in Behaviour.

Decomposition:
- Package seq_generator_pkg:
  - state enum (IDLE, SHIFT, PARITY).
  - LEN_W helper function.
  - default WIDTH/REP_W constants.
- Sub-module seq_generator_piso: a WIDTH-bit load/shift-left register with running parity, controlled by load, shift_en and reload. The FSM and counters stay in the top.

Test Plan:
- load_data=3'b101, len=3, reps=0, en=1 → dout 1,0,1 on cycles t+1..t+3; done at t+3; load_ready=1 at t+4. Driving a 101 sequence detector with this output gives one detection.
- Same pattern with reps=2 → 101101101 over 9 consecutive cycles with no gap; exactly one done; detector fires 3 times.
- len=0, load_data=8'hA5 → 8 bits 1,0,1,0,0,1,0,1; len=12 behaves the same (clamped).
- en high every 3rd cycle with pattern 2'b10 → each bit held for 3 cycles; done coincides with the en of the second bit.
- abort during the 2nd bit of an 8-bit load → dout_valid=0 the next cycle, no done, new load accepted. The same check is repeated with rst mid-transfer.
- With SEQ_GENERATOR_PARITY_EN defined: 3'b111 → 1,1,1,1; 3'b101 → 1,0,1,0; done on the parity bit.

Source files
------------

// File: rtl/seq_generator_pkg.sv
// Shared types and constants for the serial pattern generator.
// The PARITY state only becomes reachable when SEQ_GENERATOR_PARITY_EN is defined.
package seq_generator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Width of a length field that can hold every value 0..width.
  function automatic int calc_len_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_generator_piso.sv
// WIDTH-bit parallel-in / serial-out shift register, shifting left (MSB first).
// It keeps a copy of the loaded pattern so repeats can be restarted without
// reloading from the ports. It also keeps a running XOR of the bits shifted out,
// so once a whole frame has been shifted, o_parity holds the frame's even parity.
module seq_generator_piso
  import seq_generator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_reload,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb,
  output logic             o_parity
);

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_saved;
  logic             r_par;

  // Priority: a new load wins over a repeat reload, and a reload wins over a shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_saved <= '0;
      r_par   <= 1'b0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_saved <= i_data;
      r_par   <= 1'b0;
    end else if (i_reload) begin
      r_shreg <= r_saved;
      r_par   <= 1'b0;
    end else if (i_shift_en) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      r_par   <= r_par ^ r_shreg[WIDTH-1];
    end
  end

  assign o_msb    = r_shreg[WIDTH-1];
  assign o_parity = r_par;

endmodule

// File: rtl/seq_generator.sv
// Serial bit-pattern generator: accepts a right-aligned pattern, a length and
// a repeat count, then sends the pattern MSB first on dout. Repeats follow
// each other with no gap.
// Build option: SEQ_GENERATOR_PARITY_EN appends one even-parity bit to every frame.
// Handshake: a load is accepted on a rising edge where load_valid and load_ready
// are both high. load_ready is high only in IDLE. load_data, load_len and
// load_reps are sampled only at that edge.
module seq_generator
  import seq_generator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W,
  parameter int LEN_W = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_reps,
  input  logic             en,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [REP_W-1:0] ONE_R   = REP_W'(1);

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_bit_cnt, w_bit_cnt;
  logic [LEN_W-1:0] r_len_m1, w_len_m1;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt;
  logic [LEN_W-1:0] w_len;
  logic [WIDTH-1:0] w_aligned;
  logic             w_load, w_reload, w_shift;
  logic             w_msb, w_par;

  // A length of zero, or one larger than the register, means a full-width pattern.
  assign w_len     = (load_len == '0 || load_len > WIDTH_L) ? WIDTH_L : load_len;
  assign w_aligned = load_data << (WIDTH_L - w_len);

  seq_generator_piso #(.WIDTH(WIDTH)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_reload   (w_reload),
    .i_shift_en (w_shift),
    .i_data     (w_aligned),
    .o_msb      (w_msb),
    .o_parity   (w_par)
  );

  // State register and frame and repeat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_len_m1  <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_bit_cnt <= w_bit_cnt;
      r_len_m1  <= w_len_m1;
      r_rep_cnt <= w_rep_cnt;
    end
  end

  // Next-state, counter updates, shift-register control and the done pulse.
  always_comb begin
    w_next    = r_state;
    w_bit_cnt = r_bit_cnt;
    w_len_m1  = r_len_m1;
    w_rep_cnt = r_rep_cnt;
    w_load    = 1'b0;
    w_reload  = 1'b0;
    w_shift   = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_load    = 1'b1;
          w_bit_cnt = w_len - ONE_L;
          w_len_m1  = w_len - ONE_L;
          w_rep_cnt = load_reps;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_next = IDLE;
        end else if (en) begin
          if (r_bit_cnt != '0) begin
            w_shift   = 1'b1;
            w_bit_cnt = r_bit_cnt - ONE_L;
          end else begin
`ifdef SEQ_GENERATOR_PARITY_EN
            // Shifting the last data bit folds it into the running parity.
            w_shift = 1'b1;
            w_next  = PARITY;
`else
            if (r_rep_cnt != '0) begin
              w_reload  = 1'b1;
              w_bit_cnt = r_len_m1;
              w_rep_cnt = r_rep_cnt - ONE_R;
            end else begin
              w_shift = 1'b1;
              done    = 1'b1;
              w_next  = IDLE;
            end
`endif
          end
        end
      end
`ifdef SEQ_GENERATOR_PARITY_EN
      PARITY: begin
        if (abort) begin
          w_next = IDLE;
        end else if (en) begin
          if (r_rep_cnt != '0) begin
            w_reload  = 1'b1;
            w_bit_cnt = r_len_m1;
            w_rep_cnt = r_rep_cnt - ONE_R;
            w_next    = SHIFT;
          end else begin
            done   = 1'b1;
            w_next = IDLE;
          end
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // Serial outputs are selected from registers only, so no input reaches dout combinationally.
  assign load_ready = (r_state == IDLE);
  assign dout_valid = (r_state != IDLE);
  assign dout       = (r_state == SHIFT)  ? w_msb :
                      (r_state == PARITY) ? w_par : 1'b0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator. Expected bit streams are written out by hand.
// Both builds are covered: default, and SEQ_GENERATOR_PARITY_EN.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic [3:0] load_reps = '0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic       dout;
  logic       dout_valid;
  logic       done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  seq_generator dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_reps  (load_reps),
    .en         (en),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // driver: present one load for one edge, then scramble the fields
  task automatic load_pat(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    load_data  = d;
    load_len   = l;
    load_reps  = r;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 8'($urandom_range(0, 255));
    load_len   = 4'($urandom_range(0, 15));
    load_reps  = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 1'b0 ||
        done !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset: ready=%b valid=%b dout=%b done=%b state=%0d, want 1 0 0 0 0",
               load_ready, dout_valid, dout, done, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  // One accepted load; each bit is held for 'period' cycles, with en high on the last of them.
  task automatic test_pattern(input string name, input logic [7:0] d, input logic [3:0] l,
                              input logic [3:0] r, input int period,
                              input logic [31:0] bits, input int nbits, input int exp_det);
    int         det;
    int         idx;
    logic [2:0] hist;
    logic [0:0] exp_b;
    logic       exp_done;
    for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    en = 1'b1;
    load_pat(d, l, r);
    det  = 0;
    idx  = 0;
    hist = '0;
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      for (int k = 0; k < period; k++) begin
        en       = (k == period - 1);
        exp_done = en && (exp_q.size() == 0);
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b1 || dout !== exp_b) begin
          bad++;
          $display("FAIL %s bit%0d: dout=%b valid=%b, want dout=%b valid=1",
                   name, idx, dout, dout_valid, exp_b);
        end
        total++;
        if (done !== exp_done) begin
          bad++;
          $display("FAIL %s done@bit%0d: got %b want %b", name, idx, done, exp_done);
        end
        if (en) begin
          hist = {hist[1:0], dout};
          if (hist == 3'b101) det++;
        end
        @(posedge clk); #1;
      end
      idx++;
    end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1 || dout !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s end: valid=%b ready=%b dout=%b done=%b, want 0 1 0 0",
               name, dout_valid, load_ready, dout, done);
    end
    total++;
    if (det != exp_det) begin
      bad++;
      $display("FAIL %s detect101: got %0d want %0d", name, det, exp_det);
    end
    @(posedge clk); #1;
  endtask

  // load_valid held high throughout: the second load must wait for one dead IDLE cycle.
  task automatic test_back_to_back();
    logic [3:0] e1, e2;
    int         n;
`ifdef SEQ_GENERATOR_PARITY_EN
    e1 = 4'b0110; e2 = 4'b0011; n = 3;
`else
    e1 = 4'b0011; e2 = 4'b0001; n = 2;
`endif
    en = 1'b1;
    load_data = 8'h03; load_len = 4'd2; load_reps = 4'd0;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_data = 8'h01;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== 1'b1 || dout !== e1[n-1-i] || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b first bit%0d: dout=%b valid=%b ready=%b, want %b 1 0",
                 i, dout, dout_valid, load_ready, e1[n-1-i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b dead cycle: valid=%b ready=%b, want 0 1", dout_valid, load_ready);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== 1'b1 || dout !== e2[n-1-i] || done !== (i == n - 1)) begin
        bad++;
        $display("FAIL b2b second bit%0d: dout=%b valid=%b done=%b, want %b 1 %b",
                 i, dout, dout_valid, done, e2[n-1-i], (i == n - 1));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b end: valid=%b ready=%b, want 0 1", dout_valid, load_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    en = 1'b1;
    // abort while IDLE must not block a load in the same cycle
    abort = 1'b1;
    load_pat(8'h96, 4'd8, 4'd0);
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b1 || dout !== 1'b1) begin
      bad++;
      $display("FAIL abort idle load: valid=%b dout=%b, want 1 1", dout_valid, dout);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    total++;
    if (dout !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort 2nd bit: dout=%b done=%b, want 0 0", dout, done);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1 || dout !== 1'b0) begin
      bad++;
      $display("FAIL abort after: valid=%b ready=%b dout=%b, want 0 1 0",
               dout_valid, load_ready, dout);
    end
    @(posedge clk); #1;
    // abort on the only bit of a frame suppresses done
    load_pat(8'h01, 4'd1, 4'd0);
    abort = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || dout !== 1'b1) begin
      bad++;
      $display("FAIL abort last bit: done=%b dout=%b, want 0 1", done, dout);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort last after: valid=%b ready=%b, want 0 1", dout_valid, load_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    en = 1'b1;
    load_pat(8'hFF, 4'd8, 4'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid done: got %b want 0", done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0 || load_ready !== 1'b1 || dout !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid after: valid=%b ready=%b dout=%b state=%0d, want 0 1 0 0",
               dout_valid, load_ready, dout, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
`ifdef SEQ_GENERATOR_PARITY_EN
    test_pattern("basic",   8'hFD, 4'd3,  4'd0, 1, 32'b1010,         4,  1);
    test_pattern("repeat",  8'h05, 4'd3,  4'd2, 1, 32'b101010101010, 12, 5);
    test_pattern("len0",    8'hA5, 4'd0,  4'd0, 1, 32'b101001010,    9,  2);
    test_pattern("len12",   8'hA5, 4'd12, 4'd0, 1, 32'b101001010,    9,  2);
    test_pattern("slow_en", 8'h02, 4'd2,  4'd0, 3, 32'b101,          3,  1);
    test_pattern("ones",    8'h07, 4'd3,  4'd0, 1, 32'b1111,         4,  0);
`else
    test_pattern("basic",   8'hFD, 4'd3,  4'd0, 1, 32'b101,          3,  1);
    test_pattern("repeat",  8'h05, 4'd3,  4'd2, 1, 32'b101101101,    9,  3);
    test_pattern("len0",    8'hA5, 4'd0,  4'd0, 1, 32'b10100101,     8,  2);
    test_pattern("len12",   8'hA5, 4'd12, 4'd0, 1, 32'b10100101,     8,  2);
    test_pattern("slow_en", 8'h02, 4'd2,  4'd0, 3, 32'b10,           2,  0);
    test_pattern("ones",    8'h07, 4'd3,  4'd0, 1, 32'b111,          3,  0);
`endif
    test_back_to_back();
    test_abort();
`ifdef SEQ_GENERATOR_PARITY_EN
    test_pattern("post_abort", 8'h05, 4'd3, 4'd0, 1, 32'b1010, 4, 1);
`else
    test_pattern("post_abort", 8'h05, 4'd3, 4'd0, 1, 32'b101,  3, 1);
`endif
    test_rst_mid();
`ifdef SEQ_GENERATOR_PARITY_EN
    test_pattern("post_rst", 8'h05, 4'd3, 4'd0, 1, 32'b1010, 4, 1);
`else
    test_pattern("post_rst", 8'h05, 4'd3, 4'd0, 1, 32'b101,  3, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
